// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO bank: register offsets, synchroniser depth
// and the byte-enable expansion used by every write path.
package gpio_pkg;

    localparam int SYNC_STAGES = 2;

    // Byte offsets of the eight word registers (addr[1:0] is dropped before decode)
    localparam logic [4:0] OFS_OUT     = 5'h00;
    localparam logic [4:0] OFS_OUT_SET = 5'h04;
    localparam logic [4:0] OFS_OUT_CLR = 5'h08;
    localparam logic [4:0] OFS_IN      = 5'h0C;
    localparam logic [4:0] OFS_RISE_EN = 5'h10;
    localparam logic [4:0] OFS_FALL_EN = 5'h14;
    localparam logic [4:0] OFS_PENDING = 5'h18;
    localparam logic [4:0] OFS_IRQ_EN  = 5'h1C;

    // Expand the 4 byte enables into a 32-bit lane mask
    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/gpio_in_filter.sv
// One input pin: 2-FF synchroniser followed by a stability filter.
// The debounced value only follows the synchronised value after it has
// differed for DEBOUNCE consecutive cycles; DEBOUNCE=0 bypasses the filter.
module gpio_in_filter
    import gpio_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic deb_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_val;

    // Metastability guard for the asynchronous pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
        end
    end

    assign sync_val = sync_q[SYNC_STAGES-1];

    if (DEBOUNCE == 0) begin : g_bypass
        assign deb_o = sync_val;
    end else begin : g_filter
        localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
        localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE - 1);

        logic [CW-1:0] cnt_q, cnt_d;
        logic          deb_q, deb_d;

        // Count cycles of disagreement; any agreement restarts the count
        always_comb begin
            cnt_d = cnt_q;
            deb_d = deb_q;
            if (sync_val == deb_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_TC) begin
                deb_d = sync_val;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Filter state registers
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                deb_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                deb_q <= deb_d;
            end
        end

        assign deb_o = deb_q;
    end

endmodule

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: output register with atomic set/clear, filtered
// inputs, per-pin edge capture into sticky pending bits and a level irq.
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int               N_OUT     = 4,
    parameter int               N_IN      = 4,
    parameter int               DEBOUNCE  = 4,
    parameter logic [N_OUT-1:0] OUT_RESET = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  logic             we,
    input  logic             re,
    input  logic [4:0]       addr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       be,
    output logic [31:0]      rdata,
    output logic             rvalid,
    output logic [N_OUT-1:0] gpio_out,
    input  logic [N_IN-1:0]  gpio_in,
    output logic             irq
);

    logic             wr_en, rd_en;
    logic [4:0]       ofs;
    logic [31:0]      wmask, wbits;
    logic             unused_bits;

    logic [N_OUT-1:0] out_q, out_d;
    logic [N_IN-1:0]  rise_en_q, rise_en_d;
    logic [N_IN-1:0]  fall_en_q, fall_en_d;
    logic [N_IN-1:0]  pend_q, pend_d;
    logic [N_IN-1:0]  pend_clr, edge_set;
    logic [N_IN-1:0]  deb_prev_q;
    logic [N_IN-1:0]  in_deb;
    logic             irq_en_q, irq_en_d;
    logic             irq_q, irq_d;
    logic [31:0]      rd_val;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q;

    assign wr_en = sel & we;
    assign rd_en = sel & re;
    assign ofs   = {addr[4:2], 2'b00};
    assign wmask = be_mask(be);
    assign wbits = wdata & wmask;

    // Byte lanes above the pin counts and addr[1:0] have no storage behind them
    assign unused_bits = ^{addr[1:0], wbits, wmask};

    for (genvar i = 0; i < N_IN; i++) begin : g_in
        gpio_in_filter #(
            .DEBOUNCE(DEBOUNCE)
        ) u_filter (
            .clk  (clk),
            .rst_n(rst_n),
            .pin_i(gpio_in[i]),
            .deb_o(in_deb[i])
        );
    end

    // Edges are seen in the cycle after the debounced value moves, so an
    // enable written later cannot capture an edge that already happened
    assign edge_set = (in_deb & ~deb_prev_q & rise_en_q)
                    | (~in_deb & deb_prev_q & fall_en_q);

    // Register-file write decode and pending update (edge set beats W1C)
    always_comb begin
        out_d     = out_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        irq_en_d  = irq_en_q;
        pend_clr  = '0;
        if (wr_en) begin
            case (ofs)
                OFS_OUT:     out_d = (out_q & ~wmask[N_OUT-1:0]) | wbits[N_OUT-1:0];
                OFS_OUT_SET: out_d = out_q | wbits[N_OUT-1:0];
                OFS_OUT_CLR: out_d = out_q & ~wbits[N_OUT-1:0];
                OFS_RISE_EN: rise_en_d = (rise_en_q & ~wmask[N_IN-1:0]) | wbits[N_IN-1:0];
                OFS_FALL_EN: fall_en_d = (fall_en_q & ~wmask[N_IN-1:0]) | wbits[N_IN-1:0];
                OFS_PENDING: pend_clr = wbits[N_IN-1:0];
                OFS_IRQ_EN:  if (be[0]) irq_en_d = wdata[0];
                default:     ;
            endcase
        end
        pend_d = (pend_q & ~pend_clr) | edge_set;
        irq_d  = irq_en_q & (|pend_q);
    end

    // Read mux; set/clear strobes and any unmapped offset read as zero
    always_comb begin
        rd_val = '0;
        case (ofs)
            OFS_OUT:     rd_val = 32'(out_q);
            OFS_IN:      rd_val = 32'(in_deb);
            OFS_RISE_EN: rd_val = 32'(rise_en_q);
            OFS_FALL_EN: rd_val = 32'(fall_en_q);
            OFS_PENDING: rd_val = 32'(pend_q);
            OFS_IRQ_EN:  rd_val = {31'b0, irq_en_q};
            default:     rd_val = '0;
        endcase
        rdata_d = rd_en ? rd_val : rdata_q;
    end

    // Control/status registers and pin state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= OUT_RESET;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            pend_q     <= '0;
            irq_en_q   <= 1'b0;
            deb_prev_q <= '0;
        end else begin
            out_q      <= out_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            pend_q     <= pend_d;
            irq_en_q   <= irq_en_d;
            deb_prev_q <= in_deb;
        end
    end

    // Registered load response and interrupt line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rd_en;
            irq_q    <= irq_d;
        end
    end

    assign gpio_out = out_q;
    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign irq      = irq_q;

endmodule

// File: doc/gpio_bank.md
Name: gpio_bank

Overview:
- Parametrised memory-mapped GPIO bank; successor to the fixed 4-LED / 4-switch port.
- Provides N_OUT output pins with atomic set/clear, and N_IN input pins with 2-FF synchronisation and debounce.
- Adds per-pin rise/fall edge capture, sticky pending bits and a level interrupt to the core.
- Sits on the core's load/store data path, selected by the address decoder.

Parameters:
- N_OUT, 4, number of output pins (1..32)
- N_IN, 4, number of input pins (1..32)
- DEBOUNCE, 4, stable cycles required before a debounced input changes; 0 = bypass (sync only)
- OUT_RESET, 0, reset value of the output register (N_OUT bits)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sel  in  1  bank selected for the current access (one-cycle strobe)
- we  in  1  store access; valid with sel
- re  in  1  load access; valid with sel; we and re never both high
- addr  in  5  byte address; addr[4:2] selects the register, addr[1:0] ignored
- wdata  in  32  store data
- be  in  4  byte enables (sb=0001<<off, sh=0011/1100, sw=1111)
- rdata  out  32  load data, registered
- rvalid  out  1  one-cycle pulse, load data valid
- gpio_out  out  N_OUT  output pins
- gpio_in  in  N_IN  asynchronous input pins
- irq  out  1  level interrupt, registered

Behaviour:
- Reset: gpio_out=OUT_RESET, rdata=0, rvalid=0, irq=0, all enables and pending bits 0, debounced inputs 0, debounce counters 0.
- Register map (offset / access):
  - 0x00 OUT, RW
  - 0x04 OUT_SET, W1S, reads 0
  - 0x08 OUT_CLR, W1C, reads 0
  - 0x0C IN, RO, debounced value
  - 0x10 RISE_EN, RW
  - 0x14 FALL_EN, RW
  - 0x18 PENDING, RW1C
  - 0x1C IRQ_EN, bit0 only
- Bits above N_OUT/N_IN read 0 and are not stored.
- Writes: on the clk edge with sel&we. Only bytes with be[i]=1 participate; disabled bytes are treated as 0 for W1S/W1C/RW1C and leave RW bits unchanged. gpio_out changes on that same edge.
- Reads: sel&re at edge k gives rdata and rvalid=1 after edge k (1-cycle latency). rdata holds until the next load; rvalid=0 otherwise. Unmapped offsets read 0, and writes to them are ignored.
- Input path: 2-FF synchroniser, then a filter. When DEBOUNCE>0, a per-pin counter resets whenever the synchronised value equals the debounced value. Otherwise it increments each cycle, and when it reaches DEBOUNCE-1 the debounced value takes the synchronised value and the counter clears. Minimum pin-to-IN latency is 2+DEBOUNCE cycles; with DEBOUNCE=0 it is 2 cycles. Glitches shorter than DEBOUNCE cycles are never seen.
- Edge detect on the debounced value: rise = 0->1 with RISE_EN bit set; fall = 1->0 with FALL_EN bit set. Each detected edge sets the PENDING bit.
- Same-cycle edge and W1C on the same PENDING bit: the set wins and the bit stays 1.
- Enabling RISE_EN/FALL_EN does not retro-capture earlier edges.
- irq is registered: irq <= IRQ_EN[0] & |PENDING, so it lags PENDING by one cycle.
- OUT_SET and OUT_CLR with overlapping bits are separate accesses, so there is no conflict. A write to OUT in the same cycle as nothing else is a plain load.
- Async reset mid-access: the access is dropped; no rvalid follows.

Decomposition:
- gpio_pkg holds:
  - register offset constants (OFS_OUT..OFS_IRQ_EN)
  - SYNC_STAGES=2
  - a byte-enable mask function (be -> 32-bit mask)
- Sub-module gpio_in_filter (one instance per input, generate loop) holds the synchroniser, debounce counter and debounced output, parametrised by DEBOUNCE.
- Edge detect, pending logic and the register file stay in gpio_bank.

Test Plan:
- Reset then read OUT/IN/PENDING -> rdata=0 each, rvalid pulses exactly 1 cycle after each sel&re; gpio_out=OUT_RESET.
- Write OUT=0xA (sw); OUT_SET=0x1; OUT_CLR=0x8; sb 0xFF to OUT byte1 with N_OUT=12 -> gpio_out 0xA, 0xB, 0x3, then 0xF03.
- DEBOUNCE=4: pulse gpio_in[0] high 3 cycles -> IN stays 0. Hold high -> IN[0]=1 exactly 6 cycles after the pin edge.
- RISE_EN=0x1, IRQ_EN=1, raise pin0 -> PENDING=0x1 and irq=1 one cycle later. W1C 0x1 -> irq=0. Fall on pin0 with FALL_EN=0 -> no pending.
- Rise edge detected on the same cycle as a W1C of PENDING bit 0 -> PENDING[0] stays 1, irq stays 1.
- Read offset 0x04 and an unmapped address (N_IN=4, read IN with bits 31:4) -> 0 in the unused bits; a write to an unmapped offset leaves all registers unchanged.
